// File: rtl/vpe_res_collector_if.sv
// Result handshake bundle between the VPE output register, the collector
// and the deparser: push strobe/data in, FWFT head entry out, ready in.
interface vpe_res_collector_if #(
  parameter int SEQ_W = 16
);
  logic [255:0]     i_inf_res;
  logic             i_inf_res_v;
  logic [255:0]     o_res;
  logic [SEQ_W-1:0] o_res_seq;
  logic [3:0]       o_class;
  logic             o_res_v;
  logic             i_res_rdy;

  modport master (
    output i_inf_res, i_inf_res_v, i_res_rdy,
    input  o_res, o_res_seq, o_class, o_res_v
  );

  modport slave (
    input  i_inf_res, i_inf_res_v, i_res_rdy,
    output o_res, o_res_seq, o_class, o_res_v
  );
endinterface

// File: rtl/vpe_res_collector.sv
// VPE result collector: FWFT FIFO tagging each result with a sequence
// number; drops on full and flags a sticky overflow.
// Ports: clk, rst_n (async, active-low); bus (slave: i_inf_res/_v in,
// o_res/o_res_seq/o_class/o_res_v out, i_res_rdy in); i_clr_ovf,
// o_fifo_cnt, o_overflow.
// Optional: define VPE_RES_ARGMAX_EN to store the argmax lane per entry.
module vpe_res_collector #(
  parameter  int FIFO_DEPTH = 16,
  parameter  int SEQ_W      = 16,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  vpe_res_collector_if.slave  bus,
  input  logic                i_clr_ovf,
  output logic [CW-1:0]       o_fifo_cnt,
  output logic                o_overflow
);

  logic [255:0]     dat_mem [FIFO_DEPTH];
  logic [SEQ_W-1:0] seq_mem [FIFO_DEPTH];

  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic [SEQ_W-1:0] seq_q;
  logic             ovf_q;

  logic full;
  logic empty;
  logic pop;
  logic push;
  logic drop;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && bus.i_res_rdy;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push  = bus.i_inf_res_v && (!full || pop);
  assign drop  = bus.i_inf_res_v && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      seq_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + AW'(1);
        seq_q  <= seq_q + SEQ_W'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      // Set wins over a same-cycle clear.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dat_mem[wptr_q] <= bus.i_inf_res;
      seq_mem[wptr_q] <= seq_q;
    end
  end

  // Head is forced to zero when empty so reset shows all-zero outputs.
  assign bus.o_res_v   = !empty;
  assign bus.o_res     = empty ? '0 : dat_mem[rptr_q];
  assign bus.o_res_seq = empty ? '0 : seq_mem[rptr_q];
  assign o_fifo_cnt    = cnt_q;
  assign o_overflow    = ovf_q;

`ifdef VPE_RES_ARGMAX_EN
  logic [3:0]        cls_mem [FIFO_DEPTH];
  logic [3:0]        amax;
  logic signed [15:0] amax_val;
  logic signed [15:0] lane;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    amax     = 4'd0;
    amax_val = $signed(bus.i_inf_res[15:0]);
    lane     = '0;
    for (int k = 1; k < 16; k++) begin
      lane = $signed(bus.i_inf_res[16*k +: 16]);
      if (lane > amax_val) begin
        amax     = 4'(k);
        amax_val = lane;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cls_mem[wptr_q] <= amax;
    end
  end

  assign bus.o_class = empty ? 4'd0 : cls_mem[rptr_q];
`else
  assign bus.o_class = 4'd0;
`endif

endmodule

// File: tb/tb_vpe_res_collector.sv
// Scoreboard bench for vpe_res_collector: directed pushes queue expected
// entries, a negedge monitor pops and compares on each transfer.
module tb_vpe_res_collector;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

`ifdef VPE_RES_ARGMAX_EN
  localparam logic [3:0] CLS34 = 4'd5;
`else
  localparam logic [3:0] CLS34 = 4'd0;
`endif

  typedef struct {
    logic [255:0] d;
    logic [15:0]  s;
    logic [3:0]   c;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_clr_ovf = 1'b0;
  logic [CW-1:0] o_fifo_cnt;
  logic          o_overflow;

  vpe_res_collector_if #(.SEQ_W(16)) bus ();

  vpe_res_collector #(
    .FIFO_DEPTH(DEPTH),
    .SEQ_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .i_clr_ovf(i_clr_ovf),
    .o_fifo_cnt(o_fifo_cnt),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          mcnt = 0;
  logic [15:0] mseq = '0;
  logic        movf = 1'b0;
  logic [15:0] last_seq = '0;
  logic [15:0] prev_seq = '0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] amax(input logic [255:0] d);
`ifdef VPE_RES_ARGMAX_EN
    int b = 0;
    for (int k = 1; k < 16; k++)
      if ($signed(d[16*k +: 16]) > $signed(d[16*b +: 16])) b = k;
    return 4'(b);
`else
    return 4'd0;
`endif
  endfunction

  // Monitor: validity vs model occupancy, then compare on transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("o_res_v", 256'(bus.o_res_v), 256'(mcnt != 0));
      if (bus.o_res_v && bus.i_res_rdy) begin
        if (q.size() == 0) begin
          chk("unexpected_pop", 256'(1), 256'(0));
        end else begin
          e = q.pop_front();
          chk("o_res", bus.o_res, e.d);
          chk("o_res_seq", 256'(bus.o_res_seq), 256'(e.s));
          chk("o_class", 256'(bus.o_class), 256'(e.c));
          prev_seq = last_seq;
          last_seq = bus.o_res_seq;
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [255:0] d,
                     input logic rdy, input logic clr);
    logic pop;
    logic acc;
    int   nxt;
    bus.i_inf_res_v = v;
    bus.i_inf_res   = d;
    bus.i_res_rdy   = rdy;
    i_clr_ovf       = clr;
    pop = rdy && (mcnt != 0);
    acc = v && ((mcnt != DEPTH) || pop);
    if (acc) begin
      q.push_back('{d: d, s: mseq, c: amax(d)});
      mseq = mseq + 16'd1;
    end
    if (v && (mcnt == DEPTH) && !pop) movf = 1'b1;
    else if (clr) movf = 1'b0;
    nxt = mcnt + int'(acc) - int'(pop);
    @(posedge clk);
    #1;
    mcnt = nxt;
    bus.i_inf_res_v = 1'b0;
    i_clr_ovf = 1'b0;
    chk("o_fifo_cnt", 256'(o_fifo_cnt), 256'(mcnt));
    chk("o_overflow", 256'(o_overflow), 256'(movf));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_inf_res_v = 1'b0;
    bus.i_inf_res = '0;
    bus.i_res_rdy = 1'b0;
    i_clr_ovf = 1'b0;
    q.delete();
    mcnt = 0;
    mseq = '0;
    movf = 1'b0;
    #1;
    chk("rst_res_v", 256'(bus.o_res_v), 256'(0));
    chk("rst_cnt", 256'(o_fifo_cnt), 256'(0));
    chk("rst_res", bus.o_res, 256'(0));
    chk("rst_seq", 256'(bus.o_res_seq), 256'(0));
    chk("rst_class", 256'(bus.o_class), 256'(0));
    chk("rst_ovf", 256'(o_overflow), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && mcnt != 0; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("drain_done", 256'(mcnt != 0 || q.size() != 0), 256'(0));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] v34;
    logic [255:0] hold;
    logic [15:0]  hseq;
    bus.i_inf_res_v = 1'b0;
    bus.i_inf_res = '0;
    bus.i_res_rdy = 1'b0;
    do_reset();

    // Single push, head appears one cycle later then leaves.
    cyc(1'b1, 256'h1, 1'b1, 1'b0);
    chk("lat1_v", 256'(bus.o_res_v), 256'(1));
    chk("lat1_res", bus.o_res, 256'h1);
    chk("lat1_seq", 256'(bus.o_res_seq), 256'(0));
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("lat1_gone", 256'(bus.o_res_v), 256'(0));

    // Fill to full, then one dropped push.
    do_reset();
    for (int i = 0; i < 17; i++)
      cyc(1'b1, {8{32'(i + 100)}}, 1'b0, 1'b0);
    chk("full_cnt", 256'(o_fifo_cnt), 256'(16));
    chk("full_ovf", 256'(o_overflow), 256'(1));
    chk("seq_held", 256'(dut.seq_q), 256'(16));

    // Head stable while stalled.
    hold = bus.o_res;
    hseq = bus.o_res_seq;
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk("hold_res", bus.o_res, hold);
    chk("hold_seq", 256'(bus.o_res_seq), 256'(hseq));

    // Drop and clear together: set wins; then clear alone.
    cyc(1'b1, 256'hDEAD, 1'b0, 1'b1);
    chk("ovf_prio", 256'(o_overflow), 256'(1));
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", 256'(o_overflow), 256'(0));

    // Push and pop together while full.
    cyc(1'b1, 256'hBEEF, 1'b1, 1'b0);
    chk("full_pp_cnt", 256'(o_fifo_cnt), 256'(16));
    chk("full_pp_ovf", 256'(o_overflow), 256'(0));
    drain();

    // Push and pop together while partially filled.
    cyc(1'b1, 256'hA1, 1'b0, 1'b0);
    cyc(1'b1, 256'hA2, 1'b0, 1'b0);
    cyc(1'b1, 256'hA3, 1'b1, 1'b0);
    chk("mid_pp_cnt", 256'(o_fifo_cnt), 256'(2));
    drain();

    // Argmax tie toward lowest index, plus a negative-lane vector.
    v34 = {16{16'h8000}};
    v34[16*5 +: 16] = 16'h7FFF;
    v34[16*9 +: 16] = 16'h7FFF;
    cyc(1'b1, v34, 1'b0, 1'b0);
    chk("argmax_tie", 256'(bus.o_class), 256'(CLS34));
    drain();
    v34 = {16{16'hFC18}};
    v34[16*3 +: 16] = 16'hFFFB;
    v34[16*12 +: 16] = 16'h0064;
    cyc(1'b1, v34, 1'b1, 1'b0);
    drain();

    // Reset with three entries buffered.
    for (int i = 0; i < 3; i++) cyc(1'b1, 256'(i + 7), 1'b0, 1'b0);
    chk("pre_rst_cnt", 256'(o_fifo_cnt), 256'(3));
    do_reset();
    cyc(1'b1, 256'h55, 1'b0, 1'b0);
    chk("post_rst_seq", 256'(bus.o_res_seq), 256'(0));
    drain();

    // Sequence wrap.
    do_reset();
    for (int i = 0; i < 65535; i++)
      cyc(1'b1, {8{32'(i)}}, 1'b1, 1'b0);
    chk("seq_ffff", 256'(mseq), 256'(16'hFFFF));
    cyc(1'b1, 256'hF1, 1'b1, 1'b0);
    cyc(1'b1, 256'hF2, 1'b1, 1'b0);
    drain();
    chk("wrap_prev", 256'(prev_seq), 256'(16'hFFFF));
    chk("wrap_last", 256'(last_seq), 256'(16'h0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vpe_res_collector.md
VPE_RES_COLLECTOR -- requirements
Module: vpe_res_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, power of two in 4..64: number of result entries buffered.
REQ-002 Parameter SEQ_W, default 16: width of the per-result sequence tag.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_inf_res  input  256  inference result vector from the VPE output register.
REQ-006 i_inf_res_v  input  1  one-cycle strobe qualifying i_inf_res; no backpressure to the producer exists.
REQ-007 o_res  output  256  head-of-FIFO result to the deparser.
REQ-008 o_res_seq  output  SEQ_W  sequence tag of the head entry.
REQ-009 o_class  output  4  argmax lane index of the head entry (see Configuration).
REQ-010 o_res_v  output  1  head entry valid.
REQ-011 i_res_rdy  input  1  deparser ready; transfer occurs when o_res_v and i_res_rdy are both high.
REQ-012 o_fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 o_overflow  output  1  sticky flag: a result was dropped.
REQ-014 i_clr_ovf  input  1  synchronous clear of o_overflow.

Function
REQ-015 The block SHALL push i_inf_res on every cycle with i_inf_res_v high and the FIFO not full, storing data, sequence tag and class.
REQ-016 The sequence counter SHALL start at 0, increment by 1 per accepted push only, and wrap from 2^SEQ_W-1 to 0.
REQ-017 A push while full with no same-cycle pop SHALL be dropped, leave the FIFO and sequence counter unchanged, and set o_overflow the next cycle.
REQ-018 A push and pop in the same cycle while full SHALL both succeed, leaving occupancy at FIFO_DEPTH.
REQ-019 A push and pop in the same cycle while non-empty and non-full SHALL leave occupancy unchanged.
REQ-020 Outputs SHALL be first-word-fall-through: o_res, o_res_seq, o_class and o_res_v present the head entry from registered storage.
REQ-021 Latency from an accepted push into an empty FIFO to o_res_v high SHALL be exactly 1 cycle; there is no same-cycle bypass.
REQ-022 o_res, o_res_seq and o_class SHALL hold stable while o_res_v is high and i_res_rdy is low.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by occupancy count, not by pointer equality.
REQ-024 Setting o_overflow SHALL take priority over i_clr_ovf asserted in the same cycle.
REQ-025 When empty, o_res_v SHALL be 0; the o_res, o_res_seq and o_class values are don't-care.

Reset
REQ-026 On rst_n low the block SHALL, asynchronously, clear pointers, occupancy, the sequence counter and o_overflow, and drive o_res_v=0, o_res=0, o_res_seq=0, o_class=0, o_fifo_cnt=0.
REQ-027 Reset asserted mid-transfer SHALL discard all buffered entries; the first push after reset SHALL carry sequence tag 0.

Configuration
REQ-028 With macro VPE_RES_ARGMAX_EN defined, the block SHALL compute at push time the index of the maximum of 16 signed 16-bit lanes (lane k = bits [16k+15:16k]), break ties toward the lowest index, and store that index with the entry.
REQ-029 Without VPE_RES_ARGMAX_EN, o_class SHALL be constant 4'd0 and no argmax logic or class storage SHALL be built.

Verification
REQ-030 Reset, then single push of 256'h1 with i_res_rdy=1 -> o_res_v high exactly 1 cycle later with o_res=256'h1 and o_res_seq=0, then o_res_v low.
REQ-031 i_res_rdy=0, 17 consecutive pushes (FIFO_DEPTH=16) -> o_fifo_cnt=16, o_overflow=1, and drained tags are 0..15 in order.
REQ-032 FIFO full, push and i_res_rdy=1 in the same cycle -> o_fifo_cnt stays 16 and o_overflow stays 0.
REQ-033 Force the sequence counter to 16'hFFFF via 65535 prior pushes, then push 2 more -> tags 16'hFFFF then 16'h0000.
REQ-034 VPE_RES_ARGMAX_EN defined, lane 5 = 16'h7FFF, lane 9 = 16'h7FFF, all other lanes = 16'h8000 -> o_class=5; same stimulus without the macro -> o_class=0.
REQ-035 With 3 entries buffered, assert rst_n low for 1 cycle -> o_res_v=0 and o_fifo_cnt=0 immediately; the next push carries tag 0.
